// File: rtl/sdram_device_emu.sv
// sdram_device_emu: SDR SDRAM device-side responder backed by an internal RAM.
// Decodes commands, tracks per-bank rows and the mode register, and serves
// CL-delayed read bursts and zero-latency write bursts.
// Optional protocol checker: define SDRAM_EMU_PROTOCOL_CHECK_EN to build it;
// otherwise proto_err is tied low.
module sdram_device_emu #(
  parameter int W_BANKSEL = 2,
  parameter int W_ADDR    = 13,
  parameter int W_COL     = 9,
  parameter int W_DATA    = 16,
  parameter int W_MEM     = 12,
  parameter int T_RCD     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sdram_clke,
  input  logic                  sdram_cs_n,
  input  logic                  sdram_ras_n,
  input  logic                  sdram_cas_n,
  input  logic                  sdram_we_n,
  input  logic [W_BANKSEL-1:0]  sdram_ba,
  input  logic [W_ADDR-1:0]     sdram_a,
  input  logic [W_DATA/8-1:0]   sdram_dqm,
  input  logic [W_DATA-1:0]     sdram_dq_i,
  output logic [W_DATA-1:0]     sdram_dq_o,
  output logic                  sdram_dq_oe,
  output logic                  proto_err
);
  localparam int N_BANK = 1 << W_BANKSEL;
  localparam int W_BE   = W_DATA / 8;

  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_LMR = 3'b000;
  localparam logic [2:0] CMD_BST = 3'b110;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RD = 2'd1, ST_WR = 2'd2} state_e;

  if ((W_DATA % 8 != 0) || (T_RCD < 1) || (T_RCD > 15)) begin : g_param_check
    $error("sdram_device_emu: unsupported parameter set");
  end

  // Next column inside the BL-aligned block (sequential wrap).
  function automatic logic [W_COL-1:0] wrap_inc(input logic [W_COL-1:0] col, input logic [2:0] mask);
    logic [W_COL-1:0] m;
    m = W_COL'(mask);
    return (col & ~m) | ((col + W_COL'(1'b1)) & m);
  endfunction

  // Expand per-byte mask bits into a per-bit mask.
  function automatic logic [W_DATA-1:0] lane_bits(input logic [W_BE-1:0] dqm);
    logic [W_DATA-1:0] m;
    m = '0;
    for (int i = 0; i < W_BE; i++) m[i*8 +: 8] = {8{dqm[i]}};
    return m;
  endfunction

  // Backing RAM word address: {ba,row,col} truncated to the RAM size.
  function automatic logic [W_MEM-1:0] ram_addr(input logic [W_BANKSEL-1:0] ba,
                                                input logic [W_ADDR-1:0] row,
                                                input logic [W_COL-1:0] col);
    return W_MEM'({ba, row, col});
  endfunction

  state_e                           st_q, st_d;
  logic [W_BANKSEL-1:0]             bank_q, bank_d;
  logic [W_ADDR-1:0]                row_q, row_d;
  logic [W_COL-1:0]                 col_q, col_d;
  logic [3:0]                       cnt_q, cnt_d;
  logic                             ap_q, ap_d;
  logic [2:0]                       bl_mask_q, bl_mask_d;
  logic                             cl3_q, cl3_d;
  logic [N_BANK-1:0]                open_q, open_d;
  logic [N_BANK-1:0][W_ADDR-1:0]    rows_q, rows_d;
  logic [W_BE-1:0]                  dqm_q, dqm_d;
  logic                             slot_vld_q, slot_vld_d;
  logic [W_DATA-1:0]                slot_data_q, slot_data_d;
  logic [W_DATA-1:0]                dq_o_q, dq_o_d;
  logic                             dq_oe_q, dq_oe_d;

  logic [W_DATA-1:0] ram_mem [0:(1<<W_MEM)-1];
  logic              cmd_vld_s;
  logic [2:0]        cmd_s;
  logic              rd_issue_s;
  logic [W_MEM-1:0]  burst_addr_s;
  logic [W_DATA-1:0] ram_rdata_s;
  logic              ram_we_s;
  logic [W_MEM-1:0]  ram_waddr_s;
  logic [W_DATA-1:0] ram_wdata_s;
  logic [W_BE-1:0]   ram_wmask_s;
  logic              out_vld_s;
  logic [W_DATA-1:0] out_data_s;

  assign cmd_vld_s    = sdram_clke && !sdram_cs_n;
  assign cmd_s        = {sdram_ras_n, sdram_cas_n, sdram_we_n};
  assign rd_issue_s   = (st_q == ST_RD);
  assign burst_addr_s = ram_addr(bank_q, row_q, col_q);
  assign ram_rdata_s  = ram_mem[burst_addr_s];

  // Command decode, burst sequencing, read pipe and bank bookkeeping.
  always_comb begin
    st_d = st_q;  bank_d = bank_q;  row_d = row_q;  col_d = col_q;
    cnt_d = cnt_q;  ap_d = ap_q;  bl_mask_d = bl_mask_q;  cl3_d = cl3_q;
    open_d = open_q;  rows_d = rows_q;  dqm_d = dqm_q;
    slot_vld_d = slot_vld_q;  slot_data_d = slot_data_q;
    dq_o_d = dq_o_q;  dq_oe_d = dq_oe_q;
    ram_we_s = 1'b0;  ram_waddr_s = burst_addr_s;
    ram_wdata_s = sdram_dq_i;  ram_wmask_s = sdram_dqm;
    out_vld_s = 1'b0;  out_data_s = '0;
    if (sdram_clke) begin
      dqm_d       = sdram_dqm;
      slot_vld_d  = rd_issue_s;
      slot_data_d = ram_rdata_s;
      if (cl3_q) begin
        out_vld_s = slot_vld_q;  out_data_s = slot_data_q;
      end else begin
        out_vld_s = rd_issue_s;  out_data_s = ram_rdata_s;
      end
      dq_oe_d = out_vld_s;
      dq_o_d  = out_vld_s ? (out_data_s & ~lane_bits(dqm_q)) : '0;
      case (st_q)
        ST_RD, ST_WR: begin
          ram_we_s = (st_q == ST_WR);
          if (cnt_q == 4'd1) begin
            st_d = ST_IDLE;
            if (ap_q) open_d[bank_q] = 1'b0;
            else      open_d = open_q;
          end else begin
            cnt_d = cnt_q - 4'd1;
            col_d = wrap_inc(col_q, bl_mask_q);
          end
        end
        default: ;
      endcase
      if (cmd_vld_s) begin
        case (cmd_s)
          CMD_ACT: begin
            open_d[sdram_ba] = 1'b1;
            rows_d[sdram_ba] = sdram_a;
          end
          CMD_PRE: begin
            if (sdram_a[10]) open_d = '0;
            else             open_d[sdram_ba] = 1'b0;
            if (sdram_a[10] || (sdram_ba == bank_q)) begin
              st_d = ST_IDLE;  ram_we_s = 1'b0;
            end else begin
              st_d = st_d;
            end
          end
          CMD_BST: begin
            st_d = ST_IDLE;  ram_we_s = 1'b0;
          end
          CMD_LMR: begin
            case (sdram_a[2:0])
              3'b000:  bl_mask_d = 3'd0;
              3'b001:  bl_mask_d = 3'd1;
              3'b010:  bl_mask_d = 3'd3;
              default: bl_mask_d = 3'd7;
            endcase
            cl3_d = (sdram_a[6:4] != 3'b010);
          end
          CMD_RD: begin
            ram_we_s = 1'b0;
            st_d   = ST_RD;
            bank_d = sdram_ba;
            row_d  = rows_q[sdram_ba];
            col_d  = sdram_a[W_COL-1:0];
            cnt_d  = {1'b0, bl_mask_q} + 4'd1;
            ap_d   = sdram_a[10];
          end
          CMD_WR: begin
            // Beat 0 lands on the command edge; a WRITE also kills any read in flight.
            ram_we_s    = 1'b1;
            ram_waddr_s = ram_addr(sdram_ba, rows_q[sdram_ba], sdram_a[W_COL-1:0]);
            slot_vld_d  = 1'b0;
            dq_oe_d     = 1'b0;
            dq_o_d      = '0;
            bank_d = sdram_ba;
            row_d  = rows_q[sdram_ba];
            col_d  = wrap_inc(sdram_a[W_COL-1:0], bl_mask_q);
            cnt_d  = {1'b0, bl_mask_q};
            ap_d   = sdram_a[10];
            if (bl_mask_q == 3'd0) begin
              st_d = ST_IDLE;
              if (sdram_a[10]) open_d[sdram_ba] = 1'b0;
              else             open_d = open_d;
            end else begin
              st_d = ST_WR;
            end
          end
          default: ;
        endcase
      end else begin
        st_d = st_d;
      end
    end else begin
      dqm_d = dqm_q;
    end
  end

  // State registers; reset closes banks and restores BL=1, CL=2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= ST_IDLE;  bank_q <= '0;  row_q <= '0;  col_q <= '0;
      cnt_q <= 4'd0;  ap_q <= 1'b0;  bl_mask_q <= 3'd0;  cl3_q <= 1'b0;
      open_q <= '0;  rows_q <= '0;  dqm_q <= '0;
      slot_vld_q <= 1'b0;  slot_data_q <= '0;  dq_o_q <= '0;  dq_oe_q <= 1'b0;
    end else begin
      st_q <= st_d;  bank_q <= bank_d;  row_q <= row_d;  col_q <= col_d;
      cnt_q <= cnt_d;  ap_q <= ap_d;  bl_mask_q <= bl_mask_d;  cl3_q <= cl3_d;
      open_q <= open_d;  rows_q <= rows_d;  dqm_q <= dqm_d;
      slot_vld_q <= slot_vld_d;  slot_data_q <= slot_data_d;
      dq_o_q <= dq_o_d;  dq_oe_q <= dq_oe_d;
    end
  end

  // Backing RAM write port with per-byte masking; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we_s && !rst) begin
      for (int i = 0; i < W_BE; i++) begin
        if (!ram_wmask_s[i]) ram_mem[ram_waddr_s][i*8 +: 8] <= ram_wdata_s[i*8 +: 8];
      end
    end
  end

  assign sdram_dq_o  = dq_o_q;
  assign sdram_dq_oe = dq_oe_q;

`ifdef SDRAM_EMU_PROTOCOL_CHECK_EN
  logic [N_BANK-1:0][3:0] rcd_q, rcd_d;
  logic                   proto_err_q, proto_err_d;

  // Protocol checker: ACTIVE age per bank and sticky violation flag.
  always_comb begin
    rcd_d = rcd_q;
    proto_err_d = proto_err_q;
    if (sdram_clke) begin
      for (int b = 0; b < N_BANK; b++) begin
        if (rcd_q[b] < 4'(T_RCD)) rcd_d[b] = rcd_q[b] + 4'd1;
        else                      rcd_d[b] = rcd_q[b];
      end
      if (cmd_vld_s) begin
        case (cmd_s)
          CMD_ACT: begin
            if (open_q[sdram_ba]) proto_err_d = 1'b1;
            else                  proto_err_d = proto_err_q;
            rcd_d[sdram_ba] = 4'd1;
          end
          CMD_RD, CMD_WR: begin
            if (!open_q[sdram_ba] || (rcd_q[sdram_ba] < 4'(T_RCD))) proto_err_d = 1'b1;
            else                                                   proto_err_d = proto_err_q;
          end
          CMD_LMR: begin
            if (|open_q) proto_err_d = 1'b1;
            else         proto_err_d = proto_err_q;
          end
          default: ;
        endcase
      end else begin
        proto_err_d = proto_err_q;
      end
    end else begin
      rcd_d = rcd_q;
    end
  end

  // Checker registers; the flag is cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcd_q <= {N_BANK{4'(T_RCD)}};
      proto_err_q <= 1'b0;
    end else begin
      rcd_q <= rcd_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign proto_err = proto_err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_device_emu.sv
// Directed, table-driven bench for sdram_device_emu.
module tb_sdram_device_emu;
  logic        clk = 1'b0;
  logic        rst;
  logic        sdram_clke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_a;
  logic [1:0]  sdram_dqm;
  logic [15:0] sdram_dq_i;
  logic [15:0] sdram_dq_o;
  logic        sdram_dq_oe;
  logic        proto_err;

  localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100, C_PRE = 4'b0010, C_LMR = 4'b0000;
  localparam logic [3:0] C_BST = 4'b0110, C_DES = 4'b1111;
`ifdef SDRAM_EMU_PROTOCOL_CHECK_EN
  localparam logic PERR = 1'b1;
`else
  localparam logic PERR = 1'b0;
`endif

  sdram_device_emu dut (
    .clk(clk), .rst(rst), .sdram_clke(sdram_clke), .sdram_cs_n(sdram_cs_n),
    .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_ba(sdram_ba), .sdram_a(sdram_a), .sdram_dqm(sdram_dqm),
    .sdram_dq_i(sdram_dq_i), .sdram_dq_o(sdram_dq_o), .sdram_dq_oe(sdram_dq_oe),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        clke;
    logic [3:0]  c;
    logic [1:0]  ba;
    logic [12:0] a;
    logic [1:0]  dqm;
    logic [15:0] dq;
    logic        chk;
    logic [15:0] edq;
    logic        eoe;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad = 0;

  task automatic add(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                     input logic [1:0] dqm, input logic [15:0] dq,
                     input logic chk, input logic [15:0] edq, input logic eoe);
    vec_t v;
    v.clke = 1'b1; v.c = c; v.ba = ba; v.a = a; v.dqm = dqm; v.dq = dq;
    v.chk = chk; v.edq = edq; v.eoe = eoe;
    tbl.push_back(v);
  endtask

  task automatic cmd(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a);
    add(c, ba, a, 2'b00, 16'h0000, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic cmdc(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                      input logic [15:0] edq, input logic eoe);
    add(c, ba, a, 2'b00, 16'h0000, 1'b1, edq, eoe);
  endtask

  task automatic nopd(input logic [15:0] dq);
    add(C_NOP, 2'd0, 13'h0000, 2'b00, dq, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic nopc(input logic [15:0] edq, input logic eoe);
    add(C_NOP, 2'd0, 13'h0000, 2'b00, 16'h0000, 1'b1, edq, eoe);
  endtask

  task automatic stall(input logic [15:0] edq, input logic eoe);
    vec_t v;
    v.clke = 1'b0; v.c = C_DES; v.ba = 2'd0; v.a = 13'h0000; v.dqm = 2'b00;
    v.dq = 16'h0000; v.chk = 1'b1; v.edq = edq; v.eoe = eoe;
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    sdram_clke = v.clke;
    {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = v.c;
    sdram_ba = v.ba; sdram_a = v.a; sdram_dqm = v.dqm; sdram_dq_i = v.dq;
  endtask

  task automatic drive_nop();
    vec_t v;
    v.clke = 1'b1; v.c = C_NOP; v.ba = 2'd0; v.a = 13'h0000; v.dqm = 2'b00;
    v.dq = 16'h0000; v.chk = 1'b0; v.edq = 16'h0000; v.eoe = 1'b0;
    drive(v);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic run(input string scen, input logic exp_perr);
    foreach (tbl[i]) begin
      drive(tbl[i]);
      step();
      if (tbl[i].chk) begin
        check($sformatf("%s[%0d].dq_o", scen, i), 32'(sdram_dq_o), 32'(tbl[i].edq));
        check($sformatf("%s[%0d].dq_oe", scen, i), 32'(sdram_dq_oe), 32'(tbl[i].eoe));
      end
    end
    check($sformatf("%s.proto_err", scen), 32'(proto_err), 32'(exp_perr));
    tbl.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_nop();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    rst = 1'b1;
    step();
    check("reset.dq_o", 32'(sdram_dq_o), 32'h0);
    check("reset.dq_oe", 32'(sdram_dq_oe), 32'h0);
    check("reset.proto_err", 32'(proto_err), 32'h0);
    rst = 1'b0;

    // CL=2 BL=4 write then read at bank1 row5 col8.
    cmdc(C_LMR, 2'd0, 13'h022, 16'h0000, 1'b0);
    cmd(C_ACT, 2'd1, 13'd5);
    cmd(C_NOP, 2'd0, 13'd0);
    add(C_WR, 2'd1, 13'd8, 2'b00, 16'h1111, 1'b0, 16'h0000, 1'b0);
    nopd(16'h2222); nopd(16'h3333); nopd(16'h4444);
    cmdc(C_RD, 2'd1, 13'd8, 16'h0000, 1'b0);
    nopc(16'h1111, 1'b1); nopc(16'h2222, 1'b1); nopc(16'h3333, 1'b1);
    nopc(16'h4444, 1'b1); nopc(16'h0000, 1'b0);
    run("cl2", 1'b0);

    // CL=3 BL=4: read from col6 wraps 6,7,4,5.
    cmd(C_PRE, 2'd0, 13'h400);
    cmd(C_LMR, 2'd0, 13'h032);
    cmd(C_ACT, 2'd1, 13'd5);
    cmd(C_NOP, 2'd0, 13'd0);
    add(C_WR, 2'd1, 13'd4, 2'b00, 16'hA004, 1'b0, 16'h0000, 1'b0);
    nopd(16'hA005); nopd(16'hA006); nopd(16'hA007);
    cmdc(C_RD, 2'd1, 13'd6, 16'h0000, 1'b0);
    nopc(16'h0000, 1'b0);
    nopc(16'hA006, 1'b1); nopc(16'hA007, 1'b1); nopc(16'hA004, 1'b1);
    nopc(16'hA005, 1'b1); nopc(16'h0000, 1'b0);
    run("cl3", 1'b0);

    // Write byte masking and read DQM (BL=2, CL=2).
    cmd(C_PRE, 2'd0, 13'h400);
    cmd(C_LMR, 2'd0, 13'h021);
    cmd(C_ACT, 2'd0, 13'd0);
    cmd(C_NOP, 2'd0, 13'd0);
    add(C_WR, 2'd0, 13'd0, 2'b00, 16'hABCD, 1'b0, 16'h0000, 1'b0);
    nopd(16'h5555);
    add(C_WR, 2'd0, 13'd0, 2'b01, 16'h1234, 1'b0, 16'h0000, 1'b0);
    add(C_NOP, 2'd0, 13'd0, 2'b11, 16'hFFFF, 1'b0, 16'h0000, 1'b0);
    cmdc(C_RD, 2'd0, 13'd0, 16'h0000, 1'b0);
    nopc(16'h12CD, 1'b1); nopc(16'h5555, 1'b1); nopc(16'h0000, 1'b0);
    add(C_RD, 2'd0, 13'd0, 2'b10, 16'h0000, 1'b1, 16'h0000, 1'b0);
    nopc(16'h00CD, 1'b1); nopc(16'h5555, 1'b1); nopc(16'h0000, 1'b0);
    run("dqm", 1'b0);

    // BL=8: burst terminate after two beats; WRITE right after READ.
    cmd(C_PRE, 2'd0, 13'h400);
    cmd(C_LMR, 2'd0, 13'h023);
    cmd(C_ACT, 2'd0, 13'd0);
    cmd(C_NOP, 2'd0, 13'd0);
    add(C_WR, 2'd0, 13'd0, 2'b00, 16'h0100, 1'b0, 16'h0000, 1'b0);
    for (int i = 1; i < 8; i++) nopd(16'h0100 + 16'(i));
    cmdc(C_RD, 2'd0, 13'd0, 16'h0000, 1'b0);
    nopc(16'h0100, 1'b1);
    cmdc(C_BST, 2'd0, 13'd0, 16'h0101, 1'b1);
    nopc(16'h0000, 1'b0);
    nopc(16'h0000, 1'b0);
    cmdc(C_RD, 2'd0, 13'd0, 16'h0000, 1'b0);
    add(C_WR, 2'd0, 13'd0, 2'b00, 16'h7777, 1'b1, 16'h0000, 1'b0);
    cmdc(C_BST, 2'd0, 13'd0, 16'h0000, 1'b0);
    cmdc(C_RD, 2'd0, 13'd0, 16'h0000, 1'b0);
    nopc(16'h7777, 1'b1); nopc(16'h0101, 1'b1);
    cmdc(C_BST, 2'd0, 13'd0, 16'h0102, 1'b1);
    nopc(16'h0000, 1'b0);
    run("bst", 1'b0);

    // clke low for three cycles in the middle of a read burst.
    cmd(C_PRE, 2'd0, 13'h400);
    cmd(C_LMR, 2'd0, 13'h022);
    cmd(C_ACT, 2'd1, 13'd5);
    cmd(C_NOP, 2'd0, 13'd0);
    cmdc(C_RD, 2'd1, 13'd8, 16'h0000, 1'b0);
    nopc(16'h1111, 1'b1);
    stall(16'h1111, 1'b1); stall(16'h1111, 1'b1); stall(16'h1111, 1'b1);
    nopc(16'h2222, 1'b1); nopc(16'h3333, 1'b1); nopc(16'h4444, 1'b1);
    nopc(16'h0000, 1'b0);
    run("stall", 1'b0);

    // Reset asserted mid-burst drops dq_oe without a clock edge.
    cmdc(C_RD, 2'd1, 13'd8, 16'h0000, 1'b0);
    nopc(16'h1111, 1'b1);
    run("rstmid", 1'b0);
    #1;
    rst = 1'b1;
    #1;
    check("rstmid.async_dq_oe", 32'(sdram_dq_oe), 32'h0);
    check("rstmid.async_dq_o", 32'(sdram_dq_o), 32'h0);
    drive_nop();
    step();
    rst = 1'b0;

    // Post-reset mode is BL=1, CL=2.
    cmd(C_ACT, 2'd1, 13'd5);
    cmd(C_NOP, 2'd0, 13'd0);
    cmdc(C_RD, 2'd1, 13'd8, 16'h0000, 1'b0);
    nopc(16'h1111, 1'b1);
    nopc(16'h0000, 1'b0);
    run("postrst", 1'b0);

    // READ to a never-opened bank: executes with row 0, flagged when checking is built.
    cmd(C_RD, 2'd2, 13'd0);
    drive(tbl[0]);
    tbl.delete();
    step();
    check("closed.proto_err_next", 32'(proto_err), 32'(PERR));
    nopc(16'h7777, 1'b1);
    nopc(16'h0000, 1'b0);
    nopc(16'h0000, 1'b0);
    run("closed", PERR);

    // READ one cycle after ACTIVE violates T_RCD.
    do_reset();
    check("rcd.after_reset", 32'(proto_err), 32'h0);
    cmd(C_ACT, 2'd2, 13'd0);
    cmd(C_RD, 2'd2, 13'd0);
    nopc(16'h7777, 1'b1);
    run("rcd", PERR);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
